// File: rtl/spi_slave_bridge.sv
// spi_slave_bridge: SPI slave oversampled in the clk domain, bridging WIDTH-bit frames to RX/TX FIFOs
// with status/idle words, CPOL/CPHA modes, frame-length checking and overflow tracking.
module spi_slave_bridge #(
    parameter int WIDTH        = 32,
    parameter int TAG_BITS     = 4,
    parameter int RX_DEPTH     = 8,
    parameter int TX_DEPTH     = 16,
    parameter int URGENT_LEVEL = 12,
    parameter bit CPOL         = 1'b0,
    parameter bit CPHA         = 1'b0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_clk_i,
    input  logic             spi_mosi_i,
    output logic             spi_miso_o,
    input  logic             spi_cs_n_i,
    output logic             gpio_rd_valid_o,
    output logic             gpio_rd_urgent_o,
    input  logic             gpio_rd_cntreq_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_din_i,
    output logic             wr_full_o,
    input  logic             rd_en_i,
    output logic             rd_rdy_o,
    output logic [WIDTH-1:0] rd_dout_o,
    output logic             rx_overflow_o,
    output logic [7:0]       frame_err_cnt_o
);
    localparam int TA = $clog2(TX_DEPTH);
    localparam int RA = $clog2(RX_DEPTH);
    localparam int BW = $clog2(WIDTH + 2);
    localparam int MB = WIDTH - TAG_BITS - 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

    logic [SYNC_STAGES-1:0] sclk_q, mosi_q, csn_q;
    logic [SYNC_STAGES:0]   cs_ok_q;
    logic                   sclk_p_q, csn_p_q;
    logic                   sclk_s, mosi_s, csn_s, edge_s, lead_e, trail_e, sample_e, shift_e, cs_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q   <= {SYNC_STAGES{CPOL}};
            mosi_q   <= '0;
            csn_q    <= '1;
            sclk_p_q <= CPOL;
            csn_p_q  <= 1'b1;
            cs_ok_q  <= '0;
        end else begin
            sclk_q   <= {sclk_q[SYNC_STAGES-2:0], spi_clk_i};
            mosi_q   <= {mosi_q[SYNC_STAGES-2:0], spi_mosi_i};
            csn_q    <= {csn_q[SYNC_STAGES-2:0], spi_cs_n_i};
            sclk_p_q <= sclk_s;
            csn_p_q  <= csn_s;
            cs_ok_q  <= {cs_ok_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // cs_ok_q marks csn_p_q as a real pin sample, so a cs_n held low across reset never looks like a fall
    always_comb begin
        sclk_s   = sclk_q[SYNC_STAGES-1];
        mosi_s   = mosi_q[SYNC_STAGES-1];
        csn_s    = csn_q[SYNC_STAGES-1];
        edge_s   = sclk_s ^ sclk_p_q;
        lead_e   = edge_s & (sclk_p_q == CPOL);
        trail_e  = edge_s & (sclk_s == CPOL);
        sample_e = CPHA ? trail_e : lead_e;
        shift_e  = CPHA ? lead_e : trail_e;
        cs_fall  = cs_ok_q[SYNC_STAGES] & csn_p_q & ~csn_s;
    end

    logic [WIDTH-1:0] tx_mem_q [TX_DEPTH];
    logic [WIDTH-1:0] rx_mem_q [RX_DEPTH];
    logic [TA:0]      tx_wp_q, tx_rp_q, tx_cnt;
    logic [RA:0]      rx_wp_q, rx_rp_q, rx_cnt;
    logic             tx_empty, tx_full, rx_empty, rx_full, tx_push, tx_pop, rx_push, rx_drop, rx_pop;

    state_t           state_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] tx_sr_q, rx_sr_q, stat_w, idle_w;
    logic             sent_head_q, sent_stat_q, req_val_q, ack_q, ovf_q, stat_req, frame_ok, rx_tag_nz;
    logic [7:0]       err_q;

    always_comb begin
        tx_cnt    = tx_wp_q - tx_rp_q;
        rx_cnt    = rx_wp_q - rx_rp_q;
        tx_empty  = tx_cnt == '0;
        tx_full   = tx_cnt == (TA+1)'(TX_DEPTH);
        rx_empty  = rx_cnt == '0;
        rx_full   = rx_cnt == (RA+1)'(RX_DEPTH);
        stat_req  = gpio_rd_cntreq_i ^ ack_q;
        frame_ok  = state_q == COMMIT && bit_cnt_q == BW'(WIDTH);
        rx_tag_nz = |rx_sr_q[WIDTH-1 -: TAG_BITS];
        tx_push   = wr_en_i & ~tx_full;
        tx_pop    = frame_ok & sent_head_q;
        rx_push   = frame_ok & rx_tag_nz & ~rx_full;
        rx_drop   = frame_ok & rx_tag_nz & rx_full;
        rx_pop    = rd_en_i & ~rx_empty;
        idle_w         = '0;
        idle_w[MB-1]   = tx_empty;
        idle_w[MB-2]   = ovf_q;
        stat_w         = idle_w;
        stat_w[MB]     = 1'b1;
        stat_w[15:0]   = 16'(tx_cnt);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wp_q[TA-1:0]] <= wr_din_i;
        if (rx_push) rx_mem_q[rx_wp_q[RA-1:0]] <= rx_sr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            tx_wp_q <= tx_wp_q + (TA+1)'(tx_push);
            tx_rp_q <= tx_rp_q + (TA+1)'(tx_pop);
            rx_wp_q <= rx_wp_q + (RA+1)'(rx_push);
            rx_rp_q <= rx_rp_q + (RA+1)'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            sent_head_q <= 1'b0;
            sent_stat_q <= 1'b0;
            req_val_q   <= 1'b0;
            ack_q       <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_q <= LOAD;
                LOAD: begin
                    tx_sr_q     <= stat_req ? stat_w : (!tx_empty ? tx_mem_q[tx_rp_q[TA-1:0]] : idle_w);
                    sent_stat_q <= stat_req;
                    sent_head_q <= !stat_req && !tx_empty;
                    req_val_q   <= gpio_rd_cntreq_i;
                    bit_cnt_q   <= '0;
                    rx_sr_q     <= '0;
                    state_q     <= csn_s ? COMMIT : SHIFT;
                end
                SHIFT: begin
                    if (!csn_s && sample_e) begin
                        rx_sr_q   <= {rx_sr_q[WIDTH-2:0], mosi_s};
                        bit_cnt_q <= (bit_cnt_q == BW'(WIDTH + 1)) ? bit_cnt_q : bit_cnt_q + 1'b1;
                    end
                    // in CPHA=1 the first leading edge presents the preloaded MSB rather than shifting past it
                    if (!csn_s && shift_e && !(CPHA && bit_cnt_q == '0)) tx_sr_q <= {tx_sr_q[WIDTH-2:0], 1'b0};
                    if (csn_s) state_q <= COMMIT;
                end
                default: begin
                    if (bit_cnt_q == BW'(WIDTH)) begin
                        if (sent_stat_q) ack_q <= req_val_q;
                        if (rx_drop) ovf_q <= 1'b1;
                        else if (sent_stat_q) ovf_q <= 1'b0;
                    end else if (err_q != 8'hFF) begin
                        err_q <= err_q + 8'd1;
                    end
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        spi_miso_o       = tx_sr_q[WIDTH-1];
        gpio_rd_valid_o  = ~tx_empty;
        gpio_rd_urgent_o = tx_cnt >= (TA+1)'(URGENT_LEVEL);
        wr_full_o        = tx_full;
        rd_rdy_o         = ~rx_empty;
        rd_dout_o        = rx_empty ? '0 : rx_mem_q[rx_rp_q[RA-1:0]];
        rx_overflow_o    = ovf_q;
        frame_err_cnt_o  = err_q;
    end
endmodule
